inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Fetch front end; the initiator on the instruction-cache interface.
- Each cycle it probes the ICache combinationally at the current PC.
- On a hit it pushes {pc, inst} into an internal instruction queue for the decoder.
- On a miss it fetches the word from the memory controller, writes it into the ICache through the store port, then enqueues it.
- It redirects on a flush from the commit/branch logic.

Parameters:
- IQ_DEPTH, 16, instruction-queue entries (power of 2, >=2)
- RESET_PC, 32'h0, PC after reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- rdy  in  1  global enable; 0 freezes all state
- icache_addr  out  32  probe address, combinationally = pc
- icache_hit  in  1  probe hit, combinational from ICache
- icache_inst  in  32  hit data
- icache_store  out  1  one-cycle write pulse to ICache
- icache_store_addr  out  32  write address
- icache_store_inst  out  32  write data
- mem_req  out  1  level fetch request, held until mem_done
- mem_addr  out  32  word address of request
- mem_done  in  1  one-cycle completion from memory controller
- mem_data  in  32  fetched word, valid with mem_done
- flush  in  1  redirect; highest priority
- flush_pc  in  32  new PC
- iq_valid  out  1  queue head valid
- iq_inst  out  32  head instruction
- iq_pc  out  32  head PC
- iq_pop  in  1  decoder consumes head this cycle

Behaviour:
- Reset values: pc=RESET_PC, state=IDLE, queue empty, mem_req=0, mem_addr=0, icache_store=0, icache_store_addr=0, icache_store_inst=0, iq_valid=0, iq_inst=0, iq_pc=0.
- rdy=0: no register changes, icache_store forced 0, pops ignored, mem_req/mem_addr hold. A mem_done seen while rdy=0 is the controller's responsibility to hold; the bench never drives it.
- States:
  - IDLE (probing)
  - FETCH (miss outstanding)
  - DRAIN (miss outstanding, result discarded)
- IDLE, no flush, queue not full:
  - hit: push {pc, icache_inst}; pc+=4. The entry is visible on iq_valid the next cycle.
  - miss: register mem_req=1, mem_addr=pc; go FETCH. mem_req rises the cycle after the probe.
- IDLE, queue full: idle. Full is judged on the count before this cycle's pop; no same-cycle push on full.
- FETCH, mem_done=1 in the same cycle:
  - pulse icache_store with addr=mem_addr, inst=mem_data (visible the next cycle)
  - push {mem_addr, mem_data}; pc+=4
  - mem_req=0; go IDLE
  - Queue space is guaranteed because entry to FETCH required not-full.
- flush=1, any state:
  - pc<=flush_pc; queue cleared; no push that cycle; a pop that cycle is discarded.
  - IDLE: stay IDLE.
  - FETCH with no mem_done: go DRAIN; mem_req/mem_addr held, since the controller cannot cancel.
  - FETCH or DRAIN with mem_done in the same cycle: cache write still happens (the data is correct for mem_addr), no push, mem_req=0, go IDLE.
- DRAIN, mem_done:
  - cache write as above, no push
  - mem_req=0; go IDLE
  - A further flush in DRAIN only updates pc.
- Queue: circular buffer with head/tail pointers that wrap mod IQ_DEPTH and a count register 0..IQ_DEPTH.
  - iq_valid = count!=0; iq_inst/iq_pc = head entry.
  - iq_pop with iq_valid=0 is ignored.
  - Simultaneous push and pop on a non-full, non-empty queue: count unchanged.
- PC arithmetic: 32-bit, wraps at 2^32. PC low two bits are passed through unmodified; the bench uses aligned PCs.
- Reset assertion mid-miss: immediate return to reset values; any later mem_done is ignored in IDLE.

Decomposition:
- Shared header: DATA_WIDTH macro, state encodings IF_IDLE/IF_FETCH/IF_DRAIN, and the existing ICache index/tag width macros used by the bench.
- One sub-module, inst_fifo: parameterized IQ_DEPTH, 64-bit entry {pc,inst}, with push/pop/clear/full/empty and the same clk/rst.
- FSM and PC logic stay in inst_fetch.

Test Plan:
- Reset then always-hit ICache model returning inst=pc^32'hA5A5_0000, iq_pop=1 every cycle -> iq_pc sequence 0,4,8,... one per cycle; iq_inst matches; mem_req never asserted.
- Miss at pc=0x100, memory latency 3 -> mem_req=1, mem_addr=0x100 the cycle after the probe. The cycle after mem_done: icache_store=1, addr=0x100, data=mem_data, and iq_valid shows pc 0x100. The following probe is at 0x104.
- Hits with iq_pop=0 -> exactly IQ_DEPTH=16 entries, then no further pushes. One pop -> exactly one new push; head order preserved across pointer wrap.
- flush_pc=0x2000 while in FETCH -> queue empty next cycle, mem_req stays high to mem_done, cache written at the old address, no push. The next probe is at 0x2000.
- flush and mem_done in the same cycle in FETCH -> cache written, no push, IDLE, pc=flush_pc.
- rdy=0 for 5 cycles mid-stream, then rst low for 1 cycle mid-miss -> rdy=0 shows no state change and no icache_store. The rst pulse clears all outputs asynchronously, and the first probe after release is at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_fetch_pkg : shared types and widths for the instruction fetch slice |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package inst_fetch_pkg;

    localparam int unsigned c_data_width     = 32;
    localparam int unsigned c_ic_index_width = 6;
    localparam int unsigned c_ic_tag_width   = 24;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_t;

    typedef struct packed {
        logic [c_data_width-1:0] pc;
        logic [c_data_width-1:0] inst;
    } iq_entry_t;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_fetch_if : ICache probe/store and memory-controller fetch bus       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic [c_data_width-1:0] icache_addr;
    logic                    icache_hit;
    logic [c_data_width-1:0] icache_inst;
    logic                    icache_store;
    logic [c_data_width-1:0] icache_store_addr;
    logic [c_data_width-1:0] icache_store_inst;
    logic                    mem_req;
    logic [c_data_width-1:0] mem_addr;
    logic                    mem_done;
    logic [c_data_width-1:0] mem_data;

    modport master (
        output icache_addr, icache_store, icache_store_addr, icache_store_inst,
        output mem_req, mem_addr,
        input  icache_hit, icache_inst, mem_done, mem_data
    );

    modport slave (
        input  icache_addr, icache_store, icache_store_addr, icache_store_inst,
        input  mem_req, mem_addr,
        output icache_hit, icache_inst, mem_done, mem_data
    );
endinterface
`default_nettype wire

// File: rtl/inst_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_fifo : circular {pc,inst} instruction queue with clear              |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module inst_fifo
    import inst_fetch_pkg::*;
#(
    parameter int IQ_DEPTH = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      push,
    input  wire iq_entry_t push_data,
    input  wire logic      pop,
    input  wire logic      clear,
    output logic           full,
    output logic           empty,
    output iq_entry_t      head_data
);
    localparam int c_pw = $clog2(IQ_DEPTH);
    localparam int c_cw = c_pw + 1;
    localparam logic [c_pw-1:0] c_ptr_one = c_pw'(1);
    localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
    localparam logic [c_cw-1:0] c_cnt_max = c_cw'(IQ_DEPTH);

    logic [c_pw-1:0] r_head;
    logic [c_pw-1:0] r_tail;
    logic [c_cw-1:0] r_count;
    iq_entry_t       r_mem [IQ_DEPTH];
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == c_cnt_max);
    assign empty     = (r_count == '0);
    assign head_data = r_mem[r_head];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) r_mem[i] <= '0;
        end else if (clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_tail] <= push_data;
                r_tail        <= r_tail + c_ptr_one;
            end
            if (w_do_pop) r_head <= r_head + c_ptr_one;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_fetch : PC/FSM fetch front end, ICache probe, miss refill, redirect |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int          IQ_DEPTH = 16,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         rdy,
    inst_fetch_if.master      bus,
    input  wire logic         flush,
    input  wire logic [31:0]  flush_pc,
    output logic              iq_valid,
    output logic [31:0]       iq_inst,
    output logic [31:0]       iq_pc,
    input  wire logic         iq_pop
);
    localparam logic [31:0] c_pc_step = 32'd4;

    if_state_t   r_state;
    logic [31:0] r_pc;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;
    logic        r_store;
    logic [31:0] r_store_addr;
    logic [31:0] r_store_inst;

    logic        w_push;
    iq_entry_t   w_push_data;
    logic        w_pop;
    logic        w_clear;
    logic        w_full;
    logic        w_empty;
    iq_entry_t   w_head;

    assign bus.icache_addr       = r_pc;
    assign bus.icache_store      = r_store & rdy;
    assign bus.icache_store_addr = r_store_addr;
    assign bus.icache_store_inst = r_store_inst;
    assign bus.mem_req           = r_mem_req;
    assign bus.mem_addr          = r_mem_addr;

    assign iq_valid = ~w_empty;
    assign iq_pc    = w_head.pc;
    assign iq_inst  = w_head.inst;

    // A flush both clears the queue and swallows any same-cycle pop or push.
    assign w_clear = rdy & flush;
    assign w_pop   = rdy & ~flush & iq_pop;

    always_comb begin
        w_push      = 1'b0;
        w_push_data = '{pc: r_pc, inst: bus.icache_inst};
        if (rdy && !flush) begin
            if (r_state == IF_IDLE && !w_full && bus.icache_hit) begin
                w_push = 1'b1;
            end else if (r_state == IF_FETCH && bus.mem_done) begin
                w_push      = 1'b1;
                w_push_data = '{pc: r_mem_addr, inst: bus.mem_data};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IF_IDLE;
            r_pc         <= RESET_PC;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_store      <= 1'b0;
            r_store_addr <= '0;
            r_store_inst <= '0;
        end else if (rdy) begin
            r_store <= 1'b0;
            case (r_state)
                IF_IDLE: begin
                    if (flush) begin
                        r_pc <= flush_pc;
                    end else if (!w_full) begin
                        if (bus.icache_hit) begin
                            r_pc <= r_pc + c_pc_step;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_pc;
                            r_state    <= IF_FETCH;
                        end
                    end
                end
                IF_FETCH: begin
                    if (bus.mem_done) begin
                        r_store      <= 1'b1;
                        r_store_addr <= r_mem_addr;
                        r_store_inst <= bus.mem_data;
                        r_mem_req    <= 1'b0;
                        r_state      <= IF_IDLE;
                        r_pc         <= flush ? flush_pc : r_pc + c_pc_step;
                    end else if (flush) begin
                        // The controller cannot cancel, so the request stays up.
                        r_pc    <= flush_pc;
                        r_state <= IF_DRAIN;
                    end
                end
                IF_DRAIN: begin
                    if (flush) r_pc <= flush_pc;
                    if (bus.mem_done) begin
                        r_store      <= 1'b1;
                        r_store_addr <= r_mem_addr;
                        r_store_inst <= bus.mem_data;
                        r_mem_req    <= 1'b0;
                        r_state      <= IF_IDLE;
                    end
                end
                default: r_state <= IF_IDLE;
            endcase
        end
    end

    inst_fifo #(
        .IQ_DEPTH (IQ_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .clear     (w_clear),
        .full      (w_full),
        .empty     (w_empty),
        .head_data (w_head)
    );
endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_inst_fetch : directed self-checking bench for inst_fetch              |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic [31:0] flush_pc;
    logic        iq_valid;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_pop;
    logic        hit_en;
    logic [31:0] miss_addr;
    int          n_checks = 0;
    int          n_errors = 0;

    inst_fetch_if bus ();

    inst_fetch #(.IQ_DEPTH(16), .RESET_PC(32'h0)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .bus      (bus),
        .flush    (flush),
        .flush_pc (flush_pc),
        .iq_valid (iq_valid),
        .iq_inst  (iq_inst),
        .iq_pc    (iq_pc),
        .iq_pop   (iq_pop)
    );

    always #5 clk = ~clk;

    // ICache model: every address hits except miss_addr; data is pc^A5A5_0000.
    always_comb begin
        bus.icache_hit  = hit_en && (bus.icache_addr != miss_addr);
        bus.icache_inst = bus.icache_addr ^ 32'hA5A5_0000;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; flush_pc = '0; iq_pop = 1'b0;
        hit_en = 1'b0; miss_addr = 32'h100;
        bus.mem_done = 1'b0; bus.mem_data = '0;
        step(); step();
        chk("rst_valid", {31'd0, iq_valid}, 32'd0);
        chk("rst_memreq", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_store", {31'd0, bus.icache_store}, 32'd0);
        chk("rst_pc", bus.icache_addr, 32'h0);
        chk("rst_iqpc", iq_pc, 32'h0);

        // Streaming hits with continuous pop
        hit_en = 1'b1; iq_pop = 1'b1; rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("stream_valid", {31'd0, iq_valid}, 32'd1);
            chk("stream_pc", iq_pc, 32'(4 * k));
            chk("stream_inst", iq_inst, 32'(4 * k) ^ 32'hA5A5_0000);
            chk("stream_memreq", {31'd0, bus.mem_req}, 32'd0);
        end

        // Miss at 0x100, three-cycle memory latency
        flush = 1'b1; flush_pc = 32'h100; step();
        flush = 1'b0; iq_pop = 1'b0;
        chk("miss_qempty", {31'd0, iq_valid}, 32'd0);
        chk("miss_probe", bus.icache_addr, 32'h100);
        step();
        chk("miss_req", {31'd0, bus.mem_req}, 32'd1);
        chk("miss_addr", bus.mem_addr, 32'h100);
        step(); step();
        chk("miss_hold", {31'd0, bus.mem_req}, 32'd1);
        bus.mem_done = 1'b1; bus.mem_data = 32'hDEAD_BEEF; step();
        bus.mem_done = 1'b0;
        chk("miss_store", {31'd0, bus.icache_store}, 32'd1);
        chk("miss_saddr", bus.icache_store_addr, 32'h100);
        chk("miss_sdata", bus.icache_store_inst, 32'hDEAD_BEEF);
        chk("miss_iqpc", iq_pc, 32'h100);
        chk("miss_iqinst", iq_inst, 32'hDEAD_BEEF);
        chk("miss_reqdn", {31'd0, bus.mem_req}, 32'd0);
        chk("miss_next", bus.icache_addr, 32'h104);
        step();
        chk("miss_store0", {31'd0, bus.icache_store}, 32'd0);

        // Fill to 16 entries, then stall on full
        flush = 1'b1; flush_pc = 32'h400; step();
        flush = 1'b0;
        for (int k = 0; k < 18; k++) step();
        chk("full_probe", bus.icache_addr, 32'h440);
        chk("full_head", iq_pc, 32'h400);
        iq_pop = 1'b1; step(); iq_pop = 1'b0;
        chk("full_popnopush", bus.icache_addr, 32'h440);
        chk("full_head2", iq_pc, 32'h404);
        step(); step();
        chk("full_onepush", bus.icache_addr, 32'h444);
        iq_pop = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("wrap_pc", iq_pc, 32'h404 + 32'(4 * i));
            chk("wrap_inst", iq_inst, (32'h404 + 32'(4 * i)) ^ 32'hA5A5_0000);
        end
        iq_pop = 1'b0;

        // Flush while the miss is outstanding
        flush = 1'b1; flush_pc = 32'hF8; step();
        flush = 1'b0;
        step(); step(); step();
        chk("dr_valid", {31'd0, iq_valid}, 32'd1);
        chk("dr_req", {31'd0, bus.mem_req}, 32'd1);
        chk("dr_addr", bus.mem_addr, 32'h100);
        flush = 1'b1; flush_pc = 32'h2000; step();
        flush = 1'b0;
        chk("dr_qempty", {31'd0, iq_valid}, 32'd0);
        chk("dr_reqheld", {31'd0, bus.mem_req}, 32'd1);
        chk("dr_pc", bus.icache_addr, 32'h2000);
        step(); step();
        chk("dr_nopush", {31'd0, iq_valid}, 32'd0);
        chk("dr_addrheld", bus.mem_addr, 32'h100);
        bus.mem_done = 1'b1; bus.mem_data = 32'h1234_5678; step();
        bus.mem_done = 1'b0;
        chk("dr_store", {31'd0, bus.icache_store}, 32'd1);
        chk("dr_saddr", bus.icache_store_addr, 32'h100);
        chk("dr_sdata", bus.icache_store_inst, 32'h1234_5678);
        chk("dr_discard", {31'd0, iq_valid}, 32'd0);
        chk("dr_reqdn", {31'd0, bus.mem_req}, 32'd0);
        step();
        chk("dr_newpc", iq_pc, 32'h2000);
        chk("dr_store0", {31'd0, bus.icache_store}, 32'd0);

        // Flush coinciding with mem_done in FETCH
        flush = 1'b1; flush_pc = 32'h100; step();
        flush = 1'b0; step();
        flush = 1'b1; flush_pc = 32'h3000;
        bus.mem_done = 1'b1; bus.mem_data = 32'hCAFE_F00D; step();
        flush = 1'b0; bus.mem_done = 1'b0;
        chk("fd_store", {31'd0, bus.icache_store}, 32'd1);
        chk("fd_sdata", bus.icache_store_inst, 32'hCAFE_F00D);
        chk("fd_nopush", {31'd0, iq_valid}, 32'd0);
        chk("fd_reqdn", {31'd0, bus.mem_req}, 32'd0);
        chk("fd_pc", bus.icache_addr, 32'h3000);
        step();
        chk("fd_push", iq_pc, 32'h3000);

        // rdy low freezes everything, including pops
        rdy = 1'b0; iq_pop = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rdy_pc", bus.icache_addr, 32'h3004);
            chk("rdy_head", iq_pc, 32'h3000);
            chk("rdy_store", {31'd0, bus.icache_store}, 32'd0);
        end
        rdy = 1'b1; iq_pop = 1'b0;

        // Miss, then freeze, then asynchronous reset mid-miss
        flush = 1'b1; flush_pc = 32'h100; step();
        flush = 1'b0; step();
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rdym_req", {31'd0, bus.mem_req}, 32'd1);
            chk("rdym_addr", bus.mem_addr, 32'h100);
        end
        rst = 1'b0; #2;
        chk("arst_req", {31'd0, bus.mem_req}, 32'd0);
        chk("arst_addr", bus.mem_addr, 32'h0);
        chk("arst_pc", bus.icache_addr, 32'h0);
        chk("arst_valid", {31'd0, iq_valid}, 32'd0);
        rdy = 1'b1; step();
        rst = 1'b1;
        bus.mem_done = 1'b1; bus.mem_data = 32'h5555_AAAA; step();
        bus.mem_done = 1'b0;
        chk("post_valid", {31'd0, iq_valid}, 32'd1);
        chk("post_pc", iq_pc, 32'h0);
        chk("post_store", {31'd0, bus.icache_store}, 32'd0);
        chk("post_req", {31'd0, bus.mem_req}, 32'd0);
        chk("post_probe", bus.icache_addr, 32'h4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
